// File: rtl/adpll_pkg.sv
// -----------------------------------------------------------------------------
// adpll_pkg
//   Shared definitions for the ADPLL loop filter / DCO block.
//   - state_e        : loop controller state encoding (IDLE/ACQUIRE/TRACK)
//   - PERIOD_W_DEF   : default width of period words (period in clocks minus 1)
//   - MIN_PERIOD_DEF : default lower bound of the DCO period word
// -----------------------------------------------------------------------------
package adpll_pkg;

   localparam int PERIOD_W_DEF   = 10;
   localparam int MIN_PERIOD_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_TRACK   = 2'd2
   } state_e;

endpackage

// File: rtl/dco_core.sv
// -----------------------------------------------------------------------------
// dco_core
//   Free-running period counter that produces the DCO square wave.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     clear        : return everything (including dco_period) to reset values
//     seed         : restart the wave phase-aligned, loading seed_period
//     run          : oscillate; when neither clear/seed/run, cnt and output idle at 0
//     seed_period  : period word loaded on seed
//     period_nxt   : shadow period word, loaded only at a counter wrap
//     ctrl_signal  : registered DCO output (high for the first half of a period)
//     dco_period   : period word currently in use (clocks minus 1)
// -----------------------------------------------------------------------------
module dco_core
   import adpll_pkg::*;
#(
   parameter int PERIOD_W = PERIOD_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                seed,
   input  logic                run,
   input  logic [PERIOD_W-1:0] seed_period,
   input  logic [PERIOD_W-1:0] period_nxt,
   output logic                ctrl_signal,
   output logic [PERIOD_W-1:0] dco_period
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] dco_period_q, dco_period_d;
   logic                ctrl_q, ctrl_d;
   logic                wrap;

   always_comb begin
      wrap         = (cnt_q == dco_period_q);
      cnt_d        = cnt_q;
      dco_period_d = dco_period_q;
      ctrl_d       = ctrl_q;
      if (clear) begin
         cnt_d        = '0;
         dco_period_d = '0;
         ctrl_d       = 1'b0;
      end else if (seed) begin
         // Restart at phase 0 so the first output edge lines up with ref.
         cnt_d        = '0;
         dco_period_d = seed_period;
         ctrl_d       = 1'b1;
      end else if (run) begin
         // The shadow period is only taken at a wrap, so a cycle in
         // progress always completes with the length it started with.
         if (wrap) begin
            cnt_d        = '0;
            dco_period_d = period_nxt;
         end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
         end
         ctrl_d = (cnt_d <= (dco_period_d >> 1));
      end else begin
         cnt_d  = '0;
         ctrl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         dco_period_q <= '0;
         ctrl_q       <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         dco_period_q <= dco_period_d;
         ctrl_q       <= ctrl_d;
      end
   end

   assign ctrl_signal = ctrl_q;
   assign dco_period  = dco_period_q;

endmodule

// File: rtl/dco_ctrl.sv
// -----------------------------------------------------------------------------
// dco_ctrl
//   Bang-bang loop filter and DCO closing the ADPLL loop. The DCO period is
//   seeded from the measured reference period, then nudged by one clock per
//   reference cycle according to the phase detector's lead/lag pulses.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     en           : loop enable; low returns to IDLE with outputs cleared
//     lead, lag    : 1-cycle pulses one cycle after ref_rise (DCO early/late)
//     ref_rise     : 1-cycle pulse on the reference rising edge
//     ref_period   : measured reference period minus 1 (0 = not yet valid)
//     ctrl_signal  : registered DCO output fed back to the phase detector
//     dco_period   : active DCO period minus 1
//     locked       : lock indicator
//     state        : 0 IDLE, 1 ACQUIRE, 2 TRACK
// -----------------------------------------------------------------------------
module dco_ctrl
   import adpll_pkg::*;
#(
   parameter int PERIOD_W   = PERIOD_W_DEF,
   parameter int MIN_PERIOD = MIN_PERIOD_DEF,
   parameter int LOCK_CNT   = 8,
   parameter int RELOCK_TH  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                lead,
   input  logic                lag,
   input  logic                ref_rise,
   input  logic [PERIOD_W-1:0] ref_period,
   output logic                ctrl_signal,
   output logic [PERIOD_W-1:0] dco_period,
   output logic                locked,
   output logic [1:0]          state
);

   localparam int LOCK_W = $clog2(LOCK_CNT + 1);

   state_e              state_q, state_d;
   logic [PERIOD_W-1:0] period_nxt_q, period_nxt_d;
   logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic                locked_q, locked_d;
   logic signed [1:0]   last_dir_q, last_dir_d;
   logic                rr_d1_q, rr_d1_d;

   logic signed [1:0]   dir;
   logic [PERIOD_W:0]   diff;
   logic [PERIOD_W:0]   mag;
   logic                relock;
   logic                core_clear;
   logic                core_seed;
   logic                core_run;

   function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] p);
      return (p == {PERIOD_W{1'b1}}) ? p : p + PERIOD_W'(1);
   endfunction

   function automatic logic [PERIOD_W-1:0] sat_dec(input logic [PERIOD_W-1:0] p);
      return (p <= PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : p - PERIOD_W'(1);
   endfunction

   always_comb begin
      // Both pulses together carry no direction and are treated as "no change".
      dir = 2'sd0;
      if (lead && !lag) dir = 2'sd1;
      else if (lag && !lead) dir = -2'sd1;

      // One extra bit keeps the subtraction's sign so the magnitude is exact.
      diff   = {1'b0, ref_period} - {1'b0, period_nxt_q};
      mag    = diff[PERIOD_W] ? -diff : diff;
      relock = (mag > (PERIOD_W + 1)'(RELOCK_TH));
   end

   always_comb begin
      state_d      = state_q;
      period_nxt_d = period_nxt_q;
      lock_cnt_d   = lock_cnt_q;
      last_dir_d   = last_dir_q;
      core_clear   = 1'b0;
      core_seed    = 1'b0;
      core_run     = 1'b0;
      // Only reference edges seen while tracking are evaluated; the edge that
      // seeded the loop carries phase information from before the restart.
      rr_d1_d      = ref_rise && en && (state_q == ST_TRACK);

      if (!en) begin
         state_d      = ST_IDLE;
         period_nxt_d = '0;
         lock_cnt_d   = '0;
         last_dir_d   = 2'sd0;
         core_clear   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               if (ref_rise && (ref_period >= PERIOD_W'(MIN_PERIOD))) begin
                  state_d      = ST_TRACK;
                  period_nxt_d = ref_period;
                  lock_cnt_d   = '0;
                  last_dir_d   = 2'sd0;
                  core_seed    = 1'b1;
               end
            end
            ST_TRACK: begin
               core_run = 1'b1;
               if (rr_d1_q) begin
                  if (relock) begin
                     // Large frequency step: drop the correction and re-seed.
                     state_d    = ST_ACQUIRE;
                     lock_cnt_d = '0;
                     last_dir_d = 2'sd0;
                     core_run   = 1'b0;
                  end else begin
                     if (dir == 2'sd1) period_nxt_d = sat_inc(period_nxt_q);
                     else if (dir == -2'sd1) period_nxt_d = sat_dec(period_nxt_q);
                     // Repeated same-direction nudges mean the loop is still
                     // drifting; alternation (or no nudge) means it is dithering
                     // around the right period.
                     if ((dir != 2'sd0) && (dir == last_dir_q)) begin
                        lock_cnt_d = '0;
                     end else if (lock_cnt_q != LOCK_W'(LOCK_CNT)) begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                     end
                     last_dir_d = dir;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      locked_d = (lock_cnt_d == LOCK_W'(LOCK_CNT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         period_nxt_q <= '0;
         lock_cnt_q   <= '0;
         locked_q     <= 1'b0;
         last_dir_q   <= 2'sd0;
         rr_d1_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_nxt_q <= period_nxt_d;
         lock_cnt_q   <= lock_cnt_d;
         locked_q     <= locked_d;
         last_dir_q   <= last_dir_d;
         rr_d1_q      <= rr_d1_d;
      end
   end

   dco_core #(
      .PERIOD_W (PERIOD_W)
   ) u_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (core_clear),
      .seed        (core_seed),
      .run         (core_run),
      .seed_period (ref_period),
      .period_nxt  (period_nxt_q),
      .ctrl_signal (ctrl_signal),
      .dco_period  (dco_period)
   );

   assign locked = locked_q;
   assign state  = state_q;

endmodule

// File: tb/tb_dco_ctrl.sv
module tb_dco_ctrl;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       lead;
   logic       lag;
   logic       ref_rise;
   logic [9:0] ref_period;
   logic       ctrl_signal;
   logic [9:0] dco_period;
   logic       locked;
   logic [1:0] state;

   int passed;
   int total;

   dco_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .lead        (lead),
      .lag         (lag),
      .ref_rise    (ref_rise),
      .ref_period  (ref_period),
      .ctrl_signal (ctrl_signal),
      .dco_period  (dco_period),
      .locked      (locked),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One reference cycle of n clocks: ref_rise now, lead/lag pulse one cycle later.
   task automatic ref_cycle(input int n, input logic [9:0] rp, input logic ld, input logic lg);
      ref_rise = 1'b1; ref_period = rp;
      tick();
      ref_rise = 1'b0; lead = ld; lag = lg;
      tick();
      lead = 1'b0; lag = 1'b0;
      repeat (n - 2) tick();
   endtask

   task automatic restart();
      en = 1'b0; tick();
      en = 1'b1; tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; lead = 1'b0; lag = 1'b0; ref_rise = 1'b0; ref_period = '0;
      repeat (2) tick();
      total++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else passed++;
      total++; if (ctrl_signal !== 1'b0) $display("FAIL rst_ctrl: got %0b want 0", ctrl_signal); else passed++;
      total++; if (dco_period !== 10'd0) $display("FAIL rst_period: got %0d want 0", dco_period); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0b want 0", locked); else passed++;
      rst_n = 1'b1; tick();
      total++; if (state !== 2'd0) $display("FAIL idle_hold: got %0d want 0", state); else passed++;
   endtask

   task automatic test_acquire();
      int hi;
      en = 1'b1; tick();
      total++; if (state !== 2'd1) $display("FAIL acq_enter: got %0d want 1", state); else passed++;
      ref_cycle(20, 10'd0, 1'b0, 1'b0);
      total++; if (state !== 2'd1) $display("FAIL acq_ignore0: got %0d want 1", state); else passed++;
      ref_rise = 1'b1; ref_period = 10'd19; tick(); ref_rise = 1'b0;
      total++; if (state !== 2'd2) $display("FAIL acq_track: got %0d want 2", state); else passed++;
      total++; if (dco_period !== 10'd19) $display("FAIL acq_period: got %0d want 19", dco_period); else passed++;
      total++; if (ctrl_signal !== 1'b1) $display("FAIL acq_align: got %0b want 1", ctrl_signal); else passed++;
      hi = 1;
      for (int k = 1; k < 20; k++) begin
         tick();
         if (ctrl_signal === 1'b1) hi++;
      end
      total++; if (hi !== 10) $display("FAIL duty_high: got %0d want 10", hi); else passed++;
      total++; if (ctrl_signal !== 1'b0) $display("FAIL duty_last_low: got %0b want 0", ctrl_signal); else passed++;
   endtask

   task automatic test_correction();
      ref_cycle(20, 10'd19, 1'b1, 1'b0);
      total++; if (dco_period !== 10'd19) $display("FAIL lead_no_trunc: got %0d want 19", dco_period); else passed++;
      ref_rise = 1'b1; ref_period = 10'd19; tick(); ref_rise = 1'b0;
      total++; if (dco_period !== 10'd20) $display("FAIL lead_load: got %0d want 20", dco_period); else passed++;
      repeat (10) tick();
      total++; if (ctrl_signal !== 1'b1) $display("FAIL lead_hi_end: got %0b want 1", ctrl_signal); else passed++;
      tick();
      total++; if (ctrl_signal !== 1'b0) $display("FAIL lead_lo_start: got %0b want 0", ctrl_signal); else passed++;
      repeat (9) tick();
      total++; if (ctrl_signal !== 1'b0) $display("FAIL lead_21clk_lo: got %0b want 0", ctrl_signal); else passed++;
      tick();
      total++; if (ctrl_signal !== 1'b1) $display("FAIL lead_21clk_wrap: got %0b want 1", ctrl_signal); else passed++;
   endtask

   task automatic test_saturation();
      restart();
      ref_cycle(5, 10'd4, 1'b0, 1'b0);
      total++; if (dco_period !== 10'd4) $display("FAIL min_seed: got %0d want 4", dco_period); else passed++;
      ref_cycle(5, 10'd4, 1'b0, 1'b1);
      ref_cycle(5, 10'd4, 1'b0, 1'b0);
      total++; if (dco_period !== 10'd4) $display("FAIL min_sat: got %0d want 4", dco_period); else passed++;
      restart();
      ref_cycle(1024, 10'd1023, 1'b0, 1'b0);
      total++; if (dco_period !== 10'd1023) $display("FAIL max_seed: got %0d want 1023", dco_period); else passed++;
      ref_cycle(1024, 10'd1023, 1'b1, 1'b0);
      ref_cycle(1024, 10'd1023, 1'b0, 1'b0);
      total++; if (dco_period !== 10'd1023) $display("FAIL max_sat: got %0d want 1023", dco_period); else passed++;
      total++; if (state !== 2'd2) $display("FAIL max_state: got %0d want 2", state); else passed++;
   endtask

   task automatic test_lock();
      restart();
      ref_cycle(20, 10'd19, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         ref_cycle(20, 10'd19, (i % 2) == 1, (i % 2) == 0);
         if (i == 6) begin
            total++; if (locked !== 1'b0) $display("FAIL lock_early: got %0b want 0", locked); else passed++;
         end
      end
      total++; if (locked !== 1'b1) $display("FAIL lock_set: got %0b want 1", locked); else passed++;
      ref_cycle(20, 10'd19, 1'b0, 1'b1);
      total++; if (locked !== 1'b1) $display("FAIL lock_hold: got %0b want 1", locked); else passed++;
      ref_cycle(20, 10'd19, 1'b0, 1'b1);
      total++; if (locked !== 1'b0) $display("FAIL lock_drop: got %0b want 0", locked); else passed++;
   endtask

   task automatic test_relock();
      ref_rise = 1'b1; ref_period = 10'd39; tick();
      ref_rise = 1'b0; lead = 1'b1; tick(); lead = 1'b0;
      total++; if (state !== 2'd1) $display("FAIL relock_state: got %0d want 1", state); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL relock_locked: got %0b want 0", locked); else passed++;
      repeat (38) tick();
      total++; if (ctrl_signal !== 1'b0) $display("FAIL relock_idle_out: got %0b want 0", ctrl_signal); else passed++;
      ref_rise = 1'b1; ref_period = 10'd39; tick(); ref_rise = 1'b0;
      total++; if (state !== 2'd2) $display("FAIL reseed_state: got %0d want 2", state); else passed++;
      total++; if (dco_period !== 10'd39) $display("FAIL reseed_period: got %0d want 39", dco_period); else passed++;
   endtask

   task automatic test_disable();
      repeat (5) tick();
      total++; if (ctrl_signal !== 1'b1) $display("FAIL dis_pre: got %0b want 1", ctrl_signal); else passed++;
      en = 1'b0; tick();
      total++; if (state !== 2'd0) $display("FAIL dis_state: got %0d want 0", state); else passed++;
      total++; if (ctrl_signal !== 1'b0) $display("FAIL dis_ctrl: got %0b want 0", ctrl_signal); else passed++;
      total++; if (dco_period !== 10'd0) $display("FAIL dis_period: got %0d want 0", dco_period); else passed++;
      en = 1'b1; tick();
      total++; if (state !== 2'd1) $display("FAIL reen_acq: got %0d want 1", state); else passed++;
      ref_cycle(20, 10'd0, 1'b0, 1'b0);
      total++; if (state !== 2'd1) $display("FAIL reen_ignore0: got %0d want 1", state); else passed++;
      ref_rise = 1'b1; ref_period = 10'd19; tick(); ref_rise = 1'b0;
      total++; if (dco_period !== 10'd19) $display("FAIL reen_period: got %0d want 19", dco_period); else passed++;
      total++; if (state !== 2'd2) $display("FAIL reen_state: got %0d want 2", state); else passed++;
   endtask

   task automatic test_reset_mid_track();
      repeat (3) tick();
      rst_n = 1'b0; tick();
      total++; if (state !== 2'd0) $display("FAIL mid_rst_state: got %0d want 0", state); else passed++;
      total++; if (ctrl_signal !== 1'b0) $display("FAIL mid_rst_ctrl: got %0b want 0", ctrl_signal); else passed++;
      total++; if (dco_period !== 10'd0) $display("FAIL mid_rst_period: got %0d want 0", dco_period); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL mid_rst_locked: got %0b want 0", locked); else passed++;
      rst_n = 1'b1; tick();
      total++; if (state !== 2'd1) $display("FAIL post_rst_acq: got %0d want 1", state); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_acquire();
      test_correction();
      test_saturation();
      test_lock();
      test_relock();
      test_disable();
      test_reset_mid_track();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
